// File: rtl/ddr5_dfi_phase_serializer.sv
// Serializes multi-phase DFI frames (one per controller clock) into a single
// phase per clock for the DRAM-side pins, using a small frame FIFO in front.
module ddr5_dfi_phase_serializer #(
  parameter int pDRAM_SIZE  = 4,
  parameter int pNUM_RANK   = 1,
  parameter int pMAX_PHASES = 4,
  parameter int pFIFO_DEPTH = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   enable_i,
  input  logic [1:0]                             cfg_freq_ratio_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [pMAX_PHASES*pNUM_RANK-1:0]       dfi_cs_n_i,
  input  logic [pMAX_PHASES*14-1:0]              dfi_address_i,
  input  logic [pMAX_PHASES-1:0]                 dfi_wrdata_en_i,
  input  logic [pMAX_PHASES*2*pDRAM_SIZE-1:0]    dfi_wrdata_i,
  input  logic [pMAX_PHASES*pDRAM_SIZE/4-1:0]    dfi_wrdata_mask_i,
  output logic [pNUM_RANK-1:0]                   CS_n_o,
  output logic [13:0]                            CA_o,
  output logic                                   wrdata_en_o,
  output logic [2*pDRAM_SIZE-1:0]                wrdata_o,
  output logic [pDRAM_SIZE/4-1:0]                wrdata_mask_o,
  output logic                                   out_valid_o,
  output logic                                   cfg_err_o,
  output logic                                   ovf_o,
  output logic                                   dbg_state_o,
  output logic [1:0]                             dbg_ph_o,
  output logic [1:0]                             dbg_ratio_o
);
  localparam int WD   = 2 * pDRAM_SIZE;
  localparam int MW   = pDRAM_SIZE / 4;
  localparam int O_CA = pMAX_PHASES * pNUM_RANK;
  localparam int O_EN = O_CA + pMAX_PHASES * 14;
  localparam int O_WD = O_EN + pMAX_PHASES;
  localparam int O_MK = O_WD + pMAX_PHASES * WD;
  localparam int FW   = O_MK + pMAX_PHASES * MW;
  localparam int AW   = $clog2(pFIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_e;

  // Handshake: a frame transfers on a rising edge with in_valid_i=1 and
  // in_ready_o=1; a frame offered while in_ready_o=0 is lost and flagged.
  logic [FW-1:0] mem_q [pFIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, empty, push, pop;
  logic [FW-1:0] in_frame, frame_q;

  state_e        state_q;
  logic [1:0]    ph_q, ratio_q, last_ph;
  logic          ovf_q, cfg_err_q, ill_prev_q, cfg_illegal;
  logic [3:0]    cfg_n;

  logic                 out_valid_q, wd_en_q;
  logic [pNUM_RANK-1:0] cs_n_q;
  logic [13:0]          ca_q;
  logic [WD-1:0]        wd_q;
  logic [MW-1:0]        mk_q;

  assign in_frame = {dfi_wrdata_mask_i, dfi_wrdata_i, dfi_wrdata_en_i, dfi_address_i, dfi_cs_n_i};
  assign full     = (count_q == (AW+1)'(pFIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push     = in_valid_i & ~full;
  assign last_ph  = 2'((3'd1 << ratio_q) - 3'd1);
  assign pop      = enable_i & ~empty & ((state_q == IDLE) | (ph_q == last_ph));

  assign cfg_n       = 4'd1 << cfg_freq_ratio_i;
  assign cfg_illegal = (cfg_freq_ratio_i == 2'd3) | (cfg_n > 4'(pMAX_PHASES));

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_frame;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (in_valid_i && full) ovf_q <= 1'b1;
    end
  end

  // A new ratio is only adopted once nothing is loaded or queued, so every
  // frame is serialized with the ratio that was active when it was written.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ratio_q    <= 2'd1;
      cfg_err_q  <= 1'b0;
      ill_prev_q <= 1'b0;
    end else begin
      ill_prev_q <= cfg_illegal;
      cfg_err_q  <= cfg_illegal & ~ill_prev_q;
      if (!cfg_illegal && state_q == IDLE && empty) ratio_q <= cfg_freq_ratio_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      ph_q        <= 2'd0;
      frame_q     <= '0;
      out_valid_q <= 1'b0;
      cs_n_q      <= '1;
      ca_q        <= '0;
      wd_en_q     <= 1'b0;
      wd_q        <= '0;
      mk_q        <= '0;
    end else begin
      out_valid_q <= 1'b0;
      cs_n_q      <= '1;
      ca_q        <= '0;
      wd_en_q     <= 1'b0;
      wd_q        <= '0;
      mk_q        <= '0;
      if (enable_i) begin
        case (state_q)
          IDLE: begin
            if (!empty) begin
              frame_q <= mem_q[rd_ptr_q];
              ph_q    <= 2'd0;
              state_q <= SHIFT;
            end
          end
          SHIFT: begin
            out_valid_q <= 1'b1;
            cs_n_q      <= frame_q[int'(ph_q)*pNUM_RANK +: pNUM_RANK];
            ca_q        <= frame_q[O_CA + int'(ph_q)*14 +: 14];
            wd_en_q     <= frame_q[O_EN + int'(ph_q)];
            wd_q        <= frame_q[O_WD + int'(ph_q)*WD +: WD];
            mk_q        <= frame_q[O_MK + int'(ph_q)*MW +: MW];
            if (ph_q == last_ph) begin
              ph_q <= 2'd0;
              if (!empty) frame_q <= mem_q[rd_ptr_q];
              else        state_q <= IDLE;
            end else begin
              ph_q <= ph_q + 2'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign in_ready_o    = ~full;
  assign out_valid_o   = out_valid_q;
  assign CS_n_o        = cs_n_q;
  assign CA_o          = ca_q;
  assign wrdata_en_o   = wd_en_q;
  assign wrdata_o      = wd_q;
  assign wrdata_mask_o = mk_q;
  assign cfg_err_o     = cfg_err_q;
  assign ovf_o         = ovf_q;
  assign dbg_state_o   = (state_q == SHIFT);
  assign dbg_ph_o      = ph_q;
  assign dbg_ratio_o   = ratio_q;
endmodule

// File: tb/tb_ddr5_dfi_phase_serializer.sv
// Directed bench for the DFI phase serializer using default parameters
// (4-bit DQ, 1 rank, 4 phases, 4-deep FIFO).
module tb_ddr5_dfi_phase_serializer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  cfg;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cs_n_in;
  logic [55:0] addr_in;
  logic [3:0]  en_in;
  logic [31:0] wd_in;
  logic [3:0]  mk_in;
  logic        cs_n_out;
  logic [13:0] ca_out;
  logic        en_out;
  logic [7:0]  wd_out;
  logic        mk_out;
  logic        out_valid, cfg_err, ovf, dbg_state;
  logic [1:0]  dbg_ph, dbg_ratio;
  logic [25:0] obs;

  int vec_cnt = 0;
  int err_cnt = 0;

  localparam logic [25:0] IDLE_V = {1'b0, 1'b1, 14'd0, 1'b0, 8'd0, 1'b0};

  always #5 clk = ~clk;

  ddr5_dfi_phase_serializer dut (
    .clk_i(clk), .rst_i(rst_n), .enable_i(enable), .cfg_freq_ratio_i(cfg),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .dfi_cs_n_i(cs_n_in), .dfi_address_i(addr_in), .dfi_wrdata_en_i(en_in),
    .dfi_wrdata_i(wd_in), .dfi_wrdata_mask_i(mk_in),
    .CS_n_o(cs_n_out), .CA_o(ca_out), .wrdata_en_o(en_out), .wrdata_o(wd_out),
    .wrdata_mask_o(mk_out), .out_valid_o(out_valid), .cfg_err_o(cfg_err),
    .ovf_o(ovf), .dbg_state_o(dbg_state), .dbg_ph_o(dbg_ph), .dbg_ratio_o(dbg_ratio)
  );

  assign obs = {out_valid, cs_n_out, ca_out, en_out, wd_out, mk_out};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame content derived from a tag; phase p carries distinguishable fields.
  task automatic set_frame(input logic [7:0] tag);
    logic [1:0] pp;
    for (int p = 0; p < 4; p++) begin
      pp = 2'(p);
      cs_n_in[p]         = pp[0];
      addr_in[p*14 +: 14] = 14'({tag, pp});
      en_in[p]           = ~pp[0];
      wd_in[p*8 +: 8]    = tag ^ {pp, pp, pp, pp};
      mk_in[p]           = pp[1];
    end
  endtask

  function automatic logic [25:0] exp_phase(input logic [7:0] tag, input int p);
    logic [1:0] pp;
    pp = 2'(p);
    return {1'b1, pp[0], 14'({tag, pp}), ~pp[0], tag ^ {pp, pp, pp, pp}, pp[1]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; cfg = 2'd1; in_valid = 1'b0;
    cs_n_in = '1; addr_in = '0; en_in = '0; wd_in = '0; mk_in = '0;
    repeat (3) step();
    vec_cnt++;
    if (obs !== IDLE_V) begin err_cnt++; $display("FAIL reset_outputs: got %h want %h", obs, IDLE_V); end
    vec_cnt++;
    if ({in_ready, ovf, cfg_err} !== 3'b100) begin
      err_cnt++; $display("FAIL reset_flags: got rdy/ovf/err=%b want 100", {in_ready, ovf, cfg_err});
    end
    #3 rst_n = 1'b1;
    step();
    vec_cnt++;
    if (dbg_ratio !== 2'd1 || dbg_state !== 1'b0) begin
      err_cnt++; $display("FAIL reset_state: got ratio=%0d state=%0d want 1 0", dbg_ratio, dbg_state);
    end
  endtask

  task automatic test_ratio1_single();
    logic [25:0] got;
    cfg = 2'd1;
    addr_in = {14'h3fff, 14'h1234, 14'h0006, 14'h0645};
    cs_n_in = 4'b0110; en_in = '0; wd_in = '0; mk_in = '0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vec_cnt++;
      if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL r1_latency%0d: got valid=%b want 0", i, out_valid); end
      step();
    end
    got = obs;
    vec_cnt++;
    if ({got[25:24], got[23:10]} !== {2'b10, 14'h0645}) begin
      err_cnt++; $display("FAIL r1_phase0: got v/cs/ca=%b/%b/%h want 1/0/0645", got[25], got[24], got[23:10]);
    end
    step();
    got = obs;
    vec_cnt++;
    if ({got[25:24], got[23:10]} !== {2'b11, 14'h0006}) begin
      err_cnt++; $display("FAIL r1_phase1: got v/cs/ca=%b/%b/%h want 1/1/0006", got[25], got[24], got[23:10]);
    end
    step();
    vec_cnt++;
    if (obs !== IDLE_V) begin err_cnt++; $display("FAIL r1_idle: got %h want %h", obs, IDLE_V); end
  endtask

  task automatic test_back_to_back();
    logic [25:0] exp;
    cfg = 2'd2;
    step(); step();
    vec_cnt++;
    if (dbg_ratio !== 2'd2) begin err_cnt++; $display("FAIL b2b_ratio: got %0d want 2", dbg_ratio); end
    for (int f = 0; f < 3; f++) begin
      set_frame(8'hA0 + 8'(f));
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp = exp_phase(8'hA0 + 8'(i / 4), i % 4);
      vec_cnt++;
      if (obs !== exp) begin err_cnt++; $display("FAIL b2b_beat%0d: got %h want %h", i, obs, exp); end
      step();
    end
    vec_cnt++;
    if (obs !== IDLE_V) begin err_cnt++; $display("FAIL b2b_idle: got %h want %h", obs, IDLE_V); end
  endtask

  task automatic test_overflow();
    logic [25:0] exp;
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_frame(8'hB0 + 8'(k));
      in_valid = 1'b1;
      vec_cnt++;
      if (in_ready !== (k < 4)) begin err_cnt++; $display("FAIL ovf_ready%0d: got %b want %b", k, in_ready, (k < 4)); end
      step();
    end
    in_valid = 1'b0;
    vec_cnt++;
    if ({ovf, in_ready, out_valid} !== 3'b100) begin
      err_cnt++; $display("FAIL ovf_flags: got ovf/rdy/valid=%b want 100", {ovf, in_ready, out_valid});
    end
    enable = 1'b1;
    step();
    vec_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      err_cnt++; $display("FAIL ovf_first_pop: got valid=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    step();
    for (int i = 0; i < 16; i++) begin
      exp = exp_phase(8'hB0 + 8'(i / 4), i % 4);
      vec_cnt++;
      if (obs !== exp) begin err_cnt++; $display("FAIL ovf_beat%0d: got %h want %h", i, obs, exp); end
      step();
    end
    vec_cnt++;
    if (obs !== IDLE_V || ovf !== 1'b1) begin
      err_cnt++; $display("FAIL ovf_drained: got %h ovf=%b want %h ovf=1", obs, ovf, IDLE_V);
    end
  endtask

  task automatic test_ratio_change();
    logic [25:0] exp;
    cfg = 2'd1;
    step();
    vec_cnt++;
    if (dbg_ratio !== 2'd1) begin err_cnt++; $display("FAIL rc_start_ratio: got %0d want 1", dbg_ratio); end
    set_frame(8'hC0); in_valid = 1'b1;
    step();
    set_frame(8'hC1);
    step();
    cfg = 2'd0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp = exp_phase(8'hC0 + 8'(i / 2), i % 2);
      vec_cnt++;
      if (obs !== exp || dbg_ratio !== 2'd1) begin
        err_cnt++; $display("FAIL rc_old_beat%0d: got %h ratio=%0d want %h ratio=1", i, obs, dbg_ratio, exp);
      end
    end
    step();
    vec_cnt++;
    if (obs !== IDLE_V || dbg_ratio !== 2'd0) begin
      err_cnt++; $display("FAIL rc_switch: got %h ratio=%0d want %h ratio=0", obs, dbg_ratio, IDLE_V);
    end
    set_frame(8'hC2); in_valid = 1'b1;
    step();
    set_frame(8'hC3);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      exp = exp_phase(8'hC2 + 8'(i), 0);
      vec_cnt++;
      if (obs !== exp) begin err_cnt++; $display("FAIL rc_new_beat%0d: got %h want %h", i, obs, exp); end
    end
    step();
    vec_cnt++;
    if (obs !== IDLE_V) begin err_cnt++; $display("FAIL rc_idle: got %h want %h", obs, IDLE_V); end
  endtask

  task automatic test_cfg_err();
    int pulses;
    pulses = 0;
    cfg = 2'd3;
    for (int i = 0; i < 5; i++) begin step(); if (cfg_err === 1'b1) pulses++; end
    cfg = 2'd0;
    for (int i = 0; i < 2; i++) begin step(); if (cfg_err === 1'b1) pulses++; end
    vec_cnt++;
    if (pulses !== 1) begin err_cnt++; $display("FAIL cfg_err_once: got %0d pulses want 1", pulses); end
    vec_cnt++;
    if (dbg_ratio !== 2'd0) begin err_cnt++; $display("FAIL cfg_err_ratio: got %0d want 0", dbg_ratio); end
    pulses = 0;
    cfg = 2'd3;
    for (int i = 0; i < 2; i++) begin step(); if (cfg_err === 1'b1) pulses++; end
    cfg = 2'd2;
    for (int i = 0; i < 2; i++) begin step(); if (cfg_err === 1'b1) pulses++; end
    vec_cnt++;
    if (pulses !== 1 || dbg_ratio !== 2'd2) begin
      err_cnt++; $display("FAIL cfg_err_reentry: got pulses=%0d ratio=%0d want 1 2", pulses, dbg_ratio);
    end
  endtask

  task automatic test_reset_mid_frame();
    int seen;
    for (int f = 0; f < 3; f++) begin
      set_frame(8'hD0 + 8'(f)); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    vec_cnt++;
    if (obs !== exp_phase(8'hD0, 1)) begin
      err_cnt++; $display("FAIL rst_mid_phase1: got %h want %h", obs, exp_phase(8'hD0, 1));
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (obs !== IDLE_V || dbg_ratio !== 2'd1 || ovf !== 1'b0) begin
      err_cnt++; $display("FAIL rst_mid_async: got %h ratio=%0d ovf=%b want %h ratio=1 ovf=0", obs, dbg_ratio, ovf, IDLE_V);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    vec_cnt++;
    if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin step(); if (out_valid !== 1'b0) seen++; end
    vec_cnt++;
    if (seen !== 0 || dbg_state !== 1'b0) begin
      err_cnt++; $display("FAIL rst_mid_flushed: got %0d valid beats state=%0d want 0 0", seen, dbg_state);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ratio1_single();
    test_back_to_back();
    test_overflow();
    test_ratio_change();
    test_cfg_err();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
